// File: rtl/dkongjr_hs_pkg.sv
// Shared types and widths for the high-score VRAM transfer engine.
package dkongjr_hs_pkg;

  localparam int HS_AW = 10;          // VRAM port-B address width
  localparam int HS_DW = 8;           // VRAM data width
  localparam int HS_IW = HS_AW + 1;   // index width; one extra bit so a full 1024-byte window can terminate

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PAUSE   = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_CAP  = 3'd3,
    ST_TX      = 3'd4,
    ST_LD_WAIT = 3'd5,
    ST_LD_WR   = 3'd6,
    ST_DONE    = 3'd7
  } hs_state_e;

  // States that touch VRAM or accept load data and therefore need the CPU held off.
  function automatic logic is_guarded(input hs_state_e s);
    return (s == ST_RD_ADDR) || (s == ST_LD_WAIT) || (s == ST_LD_WR);
  endfunction

endpackage

// File: rtl/dkongjr_hs_xfer.sv
// High-score transfer engine: pauses the CPU, then streams a VRAM window out
// (dump) or writes a byte stream into it (load) through the secondary port.
module dkongjr_hs_xfer
  import dkongjr_hs_pkg::*;
#(
  parameter logic [HS_AW-1:0] BASE_ADDR = 10'h000,
  parameter logic [HS_IW-1:0] LENGTH    = 11'd1024
) (
  input  logic             hs_clock,
  input  logic             I_RESET,
  input  logic             I_DUMP_REQ,
  input  logic             I_LOAD_REQ,
  output logic             O_PAUSE_REQ,
  input  logic             I_PAUSE_ACK,
  output logic             O_BUSY,
  output logic             O_DONE,
  output logic [HS_DW-1:0] O_TX_DATA,
  output logic             O_TX_VALID,
  input  logic             I_TX_READY,
  input  logic [HS_DW-1:0] I_RX_DATA,
  input  logic             I_RX_VALID,
  output logic             O_RX_READY,
  output logic [HS_AW-1:0] hs_address,
  output logic [HS_DW-1:0] hs_data_in,
  input  logic [HS_DW-1:0] hs_data_out,
  output logic             hs_write,
  output logic             hs_access
);

  hs_state_e        state_q, state_d;
  logic             load_q, load_d;        // direction latched at start: 1 = load
  logic [HS_IW-1:0] idx_q, idx_d;
  logic             stall_q, stall_d;      // pause ack was low at the last edge; suppress VRAM/RX activity
  logic [HS_DW-1:0] tx_data_q, tx_data_d;
  logic [HS_DW-1:0] rx_byte_q, rx_byte_d;

  logic [HS_IW-1:0] idx_inc;
  logic             last_byte;

  assign idx_inc   = idx_q + HS_IW'(1);
  assign last_byte = (idx_inc == LENGTH);

  // State and datapath registers; reset clears everything so VRAM strobes drop immediately.
  always_ff @(posedge hs_clock or posedge I_RESET) begin
    if (I_RESET) begin
      state_q   <= ST_IDLE;
      load_q    <= 1'b0;
      idx_q     <= '0;
      stall_q   <= 1'b0;
      tx_data_q <= '0;
      rx_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      load_q    <= load_d;
      idx_q     <= idx_d;
      stall_q   <= stall_d;
      tx_data_q <= tx_data_d;
      rx_byte_q <= rx_byte_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d   = state_q;
    load_d    = load_q;
    idx_d     = idx_q;
    tx_data_d = tx_data_q;
    rx_byte_d = rx_byte_q;
    case (state_q)
      ST_IDLE: begin
        // Dump has priority when both requests coincide.
        if (I_DUMP_REQ) begin
          load_d  = 1'b0;
          idx_d   = '0;
          state_d = ST_PAUSE;
        end else if (I_LOAD_REQ) begin
          load_d  = 1'b1;
          idx_d   = '0;
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (I_PAUSE_ACK) begin
          state_d = load_q ? ST_LD_WAIT : ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        // A read issued while the ack was lost is simply repeated once it returns.
        if (!stall_q && I_PAUSE_ACK) begin
          state_d = ST_RD_CAP;
        end
      end
      ST_RD_CAP: begin
        tx_data_d = hs_data_out;
        state_d   = ST_TX;
      end
      ST_TX: begin
        if (I_TX_READY) begin
          idx_d   = idx_inc;
          state_d = last_byte ? ST_DONE : ST_RD_ADDR;
        end
      end
      ST_LD_WAIT: begin
        // A completed handshake must be honoured even if the ack dropped on the same edge.
        if (!stall_q && I_RX_VALID) begin
          rx_byte_d = I_RX_DATA;
          state_d   = ST_LD_WR;
        end
      end
      ST_LD_WR: begin
        // Rewriting the same byte after an ack loss is harmless, so only advance on a clean cycle.
        if (!stall_q && I_PAUSE_ACK) begin
          idx_d   = idx_inc;
          state_d = last_byte ? ST_DONE : ST_LD_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    stall_d = is_guarded(state_d) && !I_PAUSE_ACK;
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    O_BUSY      = (state_q != ST_IDLE);
    O_PAUSE_REQ = (state_q != ST_IDLE) && (state_q != ST_DONE);
    O_DONE      = (state_q == ST_DONE);
    O_TX_VALID  = (state_q == ST_TX);
    O_TX_DATA   = tx_data_q;
    O_RX_READY  = (state_q == ST_LD_WAIT) && !stall_q;
    hs_access   = ((state_q == ST_RD_ADDR) || (state_q == ST_LD_WR)) && !stall_q;
    hs_write    = (state_q == ST_LD_WR) && !stall_q;
    hs_data_in  = rx_byte_q;
    hs_address  = (state_q != ST_IDLE) ? (BASE_ADDR + idx_q[HS_AW-1:0]) : '0;
  end

endmodule

// File: tb/tb_dkongjr_hs_xfer.sv
// Directed bench for dkongjr_hs_xfer: three instances with different windows,
// each backed by a registered-read VRAM model.
module tb_dkongjr_hs_xfer;

  logic       clk = 1'b0;
  logic       rst       [3];
  logic       dump_req  [3];
  logic       load_req  [3];
  logic       pause_ack [3];
  logic       tx_ready  [3];
  logic       rx_valid  [3];
  logic [7:0] rx_data   [3];
  logic       pause_req [3];
  logic       busy      [3];
  logic       done      [3];
  logic       tx_valid  [3];
  logic       rx_ready  [3];
  logic       hs_write  [3];
  logic       hs_access [3];
  logic [7:0] tx_data   [3];
  logic [7:0] hs_din    [3];
  logic [7:0] hs_dout   [3];
  logic [9:0] hs_addr   [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam logic [9:0]  BASE = (gi == 0) ? 10'h100 : (gi == 1) ? 10'h3FE : 10'h200;
    localparam logic [10:0] LEN  = (gi == 2) ? 11'd1024 : 11'd4;
    logic [7:0] mem [1024];
    logic [7:0] rd_q;

    initial begin
      rd_q = 8'h00;
      for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
      if (gi == 0) for (int i = 0; i < 4; i++) mem[256 + i] = 8'hA0 + 8'(i);
    end

    always @(posedge clk) begin
      if (hs_access[gi]) begin
        if (hs_write[gi]) mem[hs_addr[gi]] <= hs_din[gi];
        rd_q <= mem[hs_addr[gi]];
      end
    end
    assign hs_dout[gi] = rd_q;

    dkongjr_hs_xfer #(.BASE_ADDR(BASE), .LENGTH(LEN)) u_dut (
      .hs_clock   (clk),
      .I_RESET    (rst[gi]),
      .I_DUMP_REQ (dump_req[gi]),
      .I_LOAD_REQ (load_req[gi]),
      .O_PAUSE_REQ(pause_req[gi]),
      .I_PAUSE_ACK(pause_ack[gi]),
      .O_BUSY     (busy[gi]),
      .O_DONE     (done[gi]),
      .O_TX_DATA  (tx_data[gi]),
      .O_TX_VALID (tx_valid[gi]),
      .I_TX_READY (tx_ready[gi]),
      .I_RX_DATA  (rx_data[gi]),
      .I_RX_VALID (rx_valid[gi]),
      .O_RX_READY (rx_ready[gi]),
      .hs_address (hs_addr[gi]),
      .hs_data_in (hs_din[gi]),
      .hs_data_out(hs_dout[gi]),
      .hs_write   (hs_write[gi]),
      .hs_access  (hs_access[gi])
    );
  end

  typedef struct packed {
    logic            is_load;        // 0: dump on instance 0, 1: load on instance 1
    int              stall_byte;     // dump byte held off by TX backpressure (-1 none)
    int              stall_cycles;
    int              ack_drop_byte;  // load byte before which the pause ack drops for 3 cycles (-1 none)
    logic [3:0][7:0] rx;
    logic [3:0][9:0] exp_addr;
    logic [3:0][7:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_idle(input int inst, input string tag);
    chk($sformatf("%s busy", tag), 32'(busy[inst]), 0);
    chk($sformatf("%s pause_req", tag), 32'(pause_req[inst]), 0);
    chk($sformatf("%s done", tag), 32'(done[inst]), 0);
    chk($sformatf("%s tx_valid", tag), 32'(tx_valid[inst]), 0);
    chk($sformatf("%s tx_data", tag), 32'(tx_data[inst]), 0);
    chk($sformatf("%s rx_ready", tag), 32'(rx_ready[inst]), 0);
    chk($sformatf("%s hs_access", tag), 32'(hs_access[inst]), 0);
    chk($sformatf("%s hs_write", tag), 32'(hs_write[inst]), 0);
    chk($sformatf("%s hs_address", tag), 32'(hs_addr[inst]), 0);
    chk($sformatf("%s hs_data_in", tag), 32'(hs_din[inst]), 0);
  endtask

  // Runs one 4-byte dump or load described by a table record and checks it cycle by cycle.
  task automatic run_vec(input int vi, input vec_t v);
    int inst, n_hs, n_acc, n_wr, n_done, cyc, stall_cnt, drop_left, first_acc, first_valid, last_hs;
    bit dropped;
    logic [7:0] held;
    inst = v.is_load ? 1 : 0;
    n_hs = 0; n_acc = 0; n_wr = 0; n_done = 0; cyc = 0; stall_cnt = 0; drop_left = 0;
    first_acc = -1; first_valid = -1; last_hs = -10; dropped = 1'b0; held = 8'h00;
    @(negedge clk);
    pause_ack[inst] = 1'b1;
    tx_ready[inst]  = 1'b1;
    rx_valid[inst]  = 1'b0;
    if (v.is_load) load_req[inst] = 1'b1;
    else           dump_req[inst] = 1'b1;
    @(negedge clk);
    load_req[inst] = 1'b0;
    dump_req[inst] = 1'b0;
    chk($sformatf("v%0d pause_req_rise", vi), 32'(pause_req[inst]), 1);
    while (n_done == 0 && cyc < 200) begin
      if (done[inst]) begin
        n_done++;
        chk($sformatf("v%0d pause_req_at_done", vi), 32'(pause_req[inst]), 0);
      end
      if (hs_access[inst]) begin
        if (first_acc < 0) first_acc = cyc;
        if (n_acc < 4) begin
          chk($sformatf("v%0d addr%0d", vi, n_acc), 32'(hs_addr[inst]), 32'(v.exp_addr[n_acc]));
          chk($sformatf("v%0d wr_strobe%0d", vi, n_acc), 32'(hs_write[inst]), 32'(v.is_load));
          if (v.is_load) begin
            chk($sformatf("v%0d wdata%0d", vi, n_acc), 32'(hs_din[inst]), 32'(v.rx[n_acc]));
            chk($sformatf("v%0d write_lag%0d", vi, n_acc), 32'(cyc), 32'(last_hs + 1));
          end
        end else begin
          chk($sformatf("v%0d extra_access", vi), 32'(n_acc), 3);
        end
        n_acc++;
      end
      if (hs_write[inst]) n_wr++;
      if (!v.is_load) begin
        if (tx_valid[inst]) begin
          if (first_valid < 0) first_valid = cyc;
          if (n_hs == v.stall_byte && stall_cnt < v.stall_cycles) begin
            if (stall_cnt == 0) held = tx_data[inst];
            else chk($sformatf("v%0d tx_stable%0d", vi, stall_cnt), 32'(tx_data[inst]), 32'(held));
            tx_ready[inst] = 1'b0;
            stall_cnt++;
          end else begin
            tx_ready[inst] = 1'b1;
            if (n_hs < 4) chk($sformatf("v%0d tx_data%0d", vi, n_hs), 32'(tx_data[inst]), 32'(v.exp_data[n_hs]));
            n_hs++;
          end
        end
      end else begin
        if (drop_left > 0) begin
          chk($sformatf("v%0d rx_ready_paused%0d", vi, drop_left), 32'(rx_ready[inst]), 0);
          chk($sformatf("v%0d access_paused%0d", vi, drop_left), 32'(hs_access[inst]), 0);
          drop_left--;
          if (drop_left == 0) pause_ack[inst] = 1'b1;
        end else if (rx_ready[inst] && n_hs < 4) begin
          if (n_hs == v.ack_drop_byte && !dropped) begin
            pause_ack[inst] = 1'b0;
            rx_valid[inst]  = 1'b0;
            dropped   = 1'b1;
            drop_left = 3;
          end else begin
            rx_valid[inst] = 1'b1;
            rx_data[inst]  = v.rx[n_hs];
            last_hs = cyc;
            n_hs++;
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    rx_valid[inst] = 1'b0;
    tx_ready[inst] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done[inst]) n_done++;
    end
    chk($sformatf("v%0d done_count", vi), 32'(n_done), 1);
    chk($sformatf("v%0d handshakes", vi), 32'(n_hs), 4);
    chk($sformatf("v%0d accesses", vi), 32'(n_acc), 4);
    chk($sformatf("v%0d busy_after", vi), 32'(busy[inst]), 0);
    if (v.is_load) begin
      chk($sformatf("v%0d write_cycles", vi), 32'(n_wr), 4);
      for (int k = 0; k < 4; k++)
        chk($sformatf("v%0d mem%0d", vi, k), 32'(g_inst[1].mem[v.exp_addr[k]]), 32'(v.rx[k]));
    end else begin
      chk($sformatf("v%0d first_valid_latency", vi), 32'(first_valid - first_acc), 2);
    end
  endtask

  initial begin
    vec_t vecs [4];
    int nhs, nrd, ndone, nrdy, aerr, derr, wr_seen;
    logic [9:0] ea;
    logic [7:0] ed;

    vecs[0] = '{is_load: 1'b0, stall_byte: -1, stall_cycles: 0, ack_drop_byte: -1, rx: '0,
                exp_addr: {10'h103, 10'h102, 10'h101, 10'h100}, exp_data: {8'hA3, 8'hA2, 8'hA1, 8'hA0}};
    vecs[1] = '{is_load: 1'b0, stall_byte: 1, stall_cycles: 5, ack_drop_byte: -1, rx: '0,
                exp_addr: {10'h103, 10'h102, 10'h101, 10'h100}, exp_data: {8'hA3, 8'hA2, 8'hA1, 8'hA0}};
    vecs[2] = '{is_load: 1'b1, stall_byte: -1, stall_cycles: 0, ack_drop_byte: -1,
                rx: {8'h44, 8'h33, 8'h22, 8'h11},
                exp_addr: {10'h001, 10'h000, 10'h3FF, 10'h3FE}, exp_data: '0};
    vecs[3] = '{is_load: 1'b1, stall_byte: -1, stall_cycles: 0, ack_drop_byte: 2,
                rx: {8'h88, 8'h77, 8'h66, 8'h55},
                exp_addr: {10'h001, 10'h000, 10'h3FF, 10'h3FE}, exp_data: '0};

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; dump_req[i] = 1'b0; load_req[i] = 1'b0; pause_ack[i] = 1'b0;
      tx_ready[i] = 1'b1; rx_valid[i] = 1'b0; rx_data[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    chk_idle(0, "reset");
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    @(negedge clk);
    chk_idle(0, "post_reset");

    for (int i = 0; i < 4; i++) begin
      run_vec(i, vecs[i]);
      $display("vector %0d %s done, checks=%0d failures=%0d", i, vecs[i].is_load ? "load" : "dump", n_checks, n_fail);
    end

    // Simultaneous requests: dump wins; a load request mid-dump is ignored.
    nhs = 0; ndone = 0; nrdy = 0; derr = 0;
    pause_ack[0] = 1'b1; tx_ready[0] = 1'b1;
    dump_req[0] = 1'b1; load_req[0] = 1'b1;
    @(negedge clk);
    dump_req[0] = 1'b0; load_req[0] = 1'b0;
    for (int c = 0; c < 80; c++) begin
      load_req[0] = (c == 6);
      if (rx_ready[0]) nrdy++;
      if (done[0]) ndone++;
      if (tx_valid[0]) begin
        if (tx_data[0] !== 8'hA0 + 8'(nhs)) derr++;
        nhs++;
      end
      @(negedge clk);
    end
    chk("both_req handshakes", 32'(nhs), 4);
    chk("both_req data_errors", 32'(derr), 0);
    chk("both_req rx_ready_cycles", 32'(nrdy), 0);
    chk("both_req done_count", 32'(ndone), 1);
    $display("simultaneous-request sequence done, checks=%0d failures=%0d", n_checks, n_fail);

    // Reset during the second write of a load on the 1024-byte instance.
    wr_seen = 0;
    pause_ack[2] = 1'b1; rx_valid[2] = 1'b1; rx_data[2] = 8'hC1;
    load_req[2] = 1'b1;
    @(negedge clk);
    load_req[2] = 1'b0;
    for (int c = 0; c < 50 && wr_seen < 2; c++) begin
      if (hs_write[2]) begin
        wr_seen++;
        rx_data[2] = 8'hC2;
      end
      if (wr_seen < 2) @(negedge clk);
    end
    chk("rst_mid wr_reached", 32'(wr_seen), 2);
    chk("rst_mid wr_addr", 32'(hs_addr[2]), 32'h201);
    rst[2] = 1'b1;
    #1;
    chk_idle(2, "rst_mid");
    @(negedge clk);
    rx_valid[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b0;
    chk("rst_mid mem200", 32'(g_inst[2].mem[10'h200]), 32'h00C1);
    chk("rst_mid mem201", 32'(g_inst[2].mem[10'h201]), 32'(8'h01 ^ 8'h5A));
    $display("reset-during-load sequence done, checks=%0d failures=%0d", n_checks, n_fail);

    // Full 1024-byte dump from 0x200, wrapping through 0x3FF to 0x1FF.
    nhs = 0; nrd = 0; ndone = 0; aerr = 0; derr = 0;
    tx_ready[2] = 1'b1;
    @(negedge clk);
    dump_req[2] = 1'b1;
    @(negedge clk);
    dump_req[2] = 1'b0;
    for (int c = 0; c < 4000 && ndone == 0; c++) begin
      if (hs_access[2]) begin
        ea = 10'h200 + 10'(nrd);
        if (hs_addr[2] !== ea || hs_write[2] !== 1'b0) aerr++;
        nrd++;
      end
      if (tx_valid[2]) begin
        ea = 10'h200 + 10'(nhs);
        ed = (ea == 10'h200) ? 8'hC1 : (8'(ea) ^ 8'h5A);
        if (tx_data[2] !== ed) begin
          if (derr == 0) $display("first bad byte at index %0d: got %0h expected %0h", nhs, tx_data[2], ed);
          derr++;
        end
        nhs++;
      end
      if (done[2]) ndone++;
      @(negedge clk);
    end
    chk("dump1024 handshakes", 32'(nhs), 1024);
    chk("dump1024 reads", 32'(nrd), 1024);
    chk("dump1024 addr_errors", 32'(aerr), 0);
    chk("dump1024 data_errors", 32'(derr), 0);
    chk("dump1024 done", 32'(ndone), 1);
    @(negedge clk);
    chk("dump1024 busy_after", 32'(busy[2]), 0);
    $display("1024-byte dump sequence done, checks=%0d failures=%0d", n_checks, n_fail);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dkongjr_hs_xfer.md
# dkongjr_hs_xfer

High-score transfer engine for the Donkey Kong Junior core: the initiator side of the tile-VRAM secondary (`hs_*`) port. It dumps a VRAM window to a byte-stream consumer and restores a window from a byte-stream producer. Before touching VRAM it pauses the CPU through a request/acknowledge handshake. It sits between the platform save/load logic and the VRAM's second port.

## Interface
- `BASE_ADDR`, default 10'h000: first VRAM byte of the window.
- `LENGTH`, default 11'd1024: bytes per transfer; legal range 1..1024.
- `hs_clock`  in  1: sole clock, also the VRAM port-B clock.
- `I_RESET`  in  1: reset, asynchronous, active-high.
- `I_DUMP_REQ`, `I_LOAD_REQ`  in  1 each: one-cycle start pulses.
- `O_PAUSE_REQ`  out  1: CPU pause request.
- `I_PAUSE_ACK`  in  1: CPU is halted, so VRAM access is permitted.
- `O_BUSY`  out  1: a transfer is in progress.
- `O_DONE`  out  1: one-cycle pulse when a transfer completes.
- `O_TX_DATA`  out  8, `O_TX_VALID`  out  1, `I_TX_READY`  in  1: dump stream.
- `I_RX_DATA`  in  8, `I_RX_VALID`  in  1, `O_RX_READY`  out  1: load stream.
- `hs_address`  out  10: VRAM port-B address.
- `hs_data_in`  out  8: VRAM write data.
- `hs_data_out`  in  8: VRAM read data. It is valid in the cycle after the address is presented.
- `hs_write`  out  1: VRAM write strobe.
- `hs_access`  out  1: VRAM chip enable.

## Operation
- States: IDLE, PAUSE, RD_ADDR, RD_CAP, TX, LD_WAIT, LD_WR, DONE.
- IDLE:
  - `I_DUMP_REQ` or `I_LOAD_REQ` latches the direction, clears the index, and goes to PAUSE.
  - If both requests arrive in the same cycle, dump wins.
  - Requests in any other state are ignored.
- PAUSE: drives `O_PAUSE_REQ`=1. On `I_PAUSE_ACK`=1 it goes to RD_ADDR (dump) or LD_WAIT (load).
- `O_PAUSE_REQ` stays 1 from PAUSE through LD_WR/TX and drops in DONE.
- Address: `hs_address` = (`BASE_ADDR` + idx) mod 1024. It wraps 10'h3FF→10'h000 inside the window.
- RD_ADDR: `hs_access`=1, `hs_write`=0, address driven; next state RD_CAP.
- RD_CAP: captures `hs_data_out` into `O_TX_DATA`; next state TX.
- TX: `O_TX_VALID`=1, data held stable. On `I_TX_READY`, idx increments; if idx reaches `LENGTH` go to DONE, else RD_ADDR.
- LD_WAIT: `O_RX_READY`=1. On `I_RX_VALID`, captures `I_RX_DATA` and goes to LD_WR.
- LD_WR: one cycle with `hs_access`=1, `hs_write`=1, `hs_data_in` = captured byte. idx increments; go to DONE at `LENGTH`, else LD_WAIT.
- DONE: `O_DONE`=1 for one cycle, then IDLE.
- `O_BUSY`=1 in every state except IDLE.
- Pause loss: if `I_PAUSE_ACK` falls in RD_ADDR, LD_WR or LD_WAIT, the FSM holds that state with `hs_access`=0 and `O_RX_READY`=0 until the ack returns. TX and RD_CAP are unaffected.
- idx is 11 bits, so `LENGTH`=1024 terminates correctly.
- Reset, including mid-transfer: state IDLE and every output 0 (`O_PAUSE_REQ`, `O_BUSY`, `O_DONE`, `O_TX_VALID`, `O_TX_DATA`, `O_RX_READY`, `hs_*`). `hs_access` and `hs_write` drop asynchronously; no partial write is completed.

## Timing
- Request to `O_PAUSE_REQ` high: 1 cycle.
- `I_PAUSE_ACK` to first `hs_access`: 1 cycle.
- Dump: 3 cycles per byte with `I_TX_READY` held high. The first `O_TX_VALID` comes 2 cycles after RD_ADDR.
- Load: 2 cycles per byte with `I_RX_VALID` held high. The write occurs the cycle after the RX handshake.
- The last handshake is followed by DONE one cycle later.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Structure
- Package `dkongjr_hs_pkg` holds:
  - the state enum;
  - `HS_AW`=10 and `HS_DW`=8;
  - the idx width (`HS_AW`+1).
- No sub-module: one FSM plus the address/index datapath.

## Test plan
- Dump, `BASE_ADDR`=10'h100, `LENGTH`=4, RAM model preloaded with 8'hA0..A3, `I_TX_READY`=1, ack immediate → stream A0,A1,A2,A3 on addresses 100..103; `O_DONE` pulses once; `O_PAUSE_REQ` falls in the same cycle.
- Load, `BASE_ADDR`=10'h3FE, `LENGTH`=4, bytes 11,22,33,44 → writes at 3FE,3FF,000,001; `hs_write` is high exactly 4 cycles.
- Dump under TX backpressure: `I_TX_READY` low for 5 cycles on byte 2 → `O_TX_DATA` stays stable, no extra `hs_access`, byte order is preserved.
- `I_DUMP_REQ` and `I_LOAD_REQ` in the same cycle → dump runs. `I_LOAD_REQ` during the dump is ignored and produces no second `O_DONE`.
- `I_PAUSE_ACK` dropped for 3 cycles during a load → `hs_access`=0 and `O_RX_READY`=0 for those cycles; transfer resumes and completes with correct contents.
- `I_RESET` asserted during LD_WR of byte 2 → `hs_write` falls without waiting for a clock edge and all outputs are 0. A following `LENGTH`=1024 dump returns all 1024 bytes and ends with `O_DONE`.
